// File: rtl/mult_acc_stage.sv
// Dot-product accumulation stage behind mult_top: tracks the fixed 2-cycle multiplier latency,
// buffers products in a credit-guarded FIFO and sums VEC_LEN of them per saturating result.
module mult_acc_stage #(
  parameter int P_W        = 32,
  parameter int VEC_LEN    = 8,
  parameter int ACC_W      = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             clr,
  input  logic [P_W-1:0]   p_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_sat,
  output logic             acc_valid,
  input  logic             acc_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(VEC_LEN - 1);
  localparam logic [OCC_W:0]   CREDIT_MAX = (OCC_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Returns {overflow, value}; on carry-out the value is clamped to all-ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [P_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = (ACC_W + 1)'(a) + (ACC_W + 1)'(b);
    if (sum[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end else begin
      return sum;
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  state_t             state_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sticky_r;
  logic               v1_r;
  logic               v2_r;
  logic [P_W-1:0]     mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [OCC_W-1:0]   occ_r;

  logic               push_s;
  logic               pop_s;
  logic               last_s;
  logic [P_W-1:0]     head_s;
  logic [ACC_W:0]     add_s;
  logic [OCC_W:0]     inflight_s;
  logic               op_ready_s;

  // Datapath decode: FIFO head, saturating sum and credit check, all from registered state.
  always_comb begin
    head_s     = mem_r[rd_ptr_r];
    push_s     = v2_r;
    pop_s      = (state_r == ST_ACC) && (occ_r != {OCC_W{1'b0}});
    last_s     = (cnt_r == CNT_LAST);
    add_s      = sat_add(acc_r, head_s);
    inflight_s = (OCC_W + 1)'(occ_r) + (OCC_W + 1)'(v1_r) + (OCC_W + 1)'(v2_r);
    op_ready_s = (inflight_s < CREDIT_MAX);
  end

  assign op_ready = op_ready_s;

  // Latency tag: mirrors the two register stages inside mult_top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else if (clr) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      v1_r <= op_valid & op_ready_s;
      v2_r <= v1_r;
    end
  end

  // Product storage; p_in is only captured when its tag arrives.
  always_ff @(posedge clk) begin
    if (push_s && !clr) begin
      mem_r[wr_ptr_r] <= p_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Accumulate/offer FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_ACC;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      sticky_r  <= 1'b0;
      acc_out   <= {ACC_W{1'b0}};
      acc_sat   <= 1'b0;
      acc_valid <= 1'b0;
    end else if (clr) begin
      state_r   <= ST_ACC;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      sticky_r  <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (pop_s) begin
            if (last_s) begin
              acc_out   <= add_s[ACC_W-1:0];
              acc_sat   <= sticky_r | add_s[ACC_W];
              acc_valid <= 1'b1;
              acc_r     <= {ACC_W{1'b0}};
              cnt_r     <= {CNT_W{1'b0}};
              sticky_r  <= sticky_r | add_s[ACC_W];
              state_r   <= ST_DONE;
            end else begin
              acc_r    <= add_s[ACC_W-1:0];
              cnt_r    <= cnt_r + CNT_W'(1);
              sticky_r <= sticky_r | add_s[ACC_W];
            end
          end
        end
        ST_DONE: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            sticky_r  <= 1'b0;
            state_r   <= ST_ACC;
          end
        end
        default: begin
          acc_valid <= 1'b0;
          state_r   <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Self-checking bench for mult_acc_stage: table of hand-computed dot products plus
// directed sequences for latency, back-pressure, clr, async reset and a random soak.
`timescale 1ns/100ps
module tb_mult_acc_stage;

  localparam int P_W        = 32;
  localparam int VEC_LEN    = 8;
  localparam int ACC_W      = 34;
  localparam int FIFO_DEPTH = 4;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             op_valid  = 1'b0;
  logic             op_ready;
  logic             clr       = 1'b0;
  logic [P_W-1:0]   p_in;
  logic [ACC_W-1:0] acc_out;
  logic             acc_sat;
  logic             acc_valid;
  logic             acc_ready = 1'b0;

  always #5 clk = ~clk;

  mult_acc_stage #(
    .P_W(P_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .clr(clr),
    .p_in(p_in), .acc_out(acc_out), .acc_sat(acc_sat), .acc_valid(acc_valid),
    .acc_ready(acc_ready)
  );

  typedef struct packed {
    logic [VEC_LEN-1:0][P_W-1:0] p;
    logic [ACC_W-1:0]            sum;
    logic                        sat;
  } vec_t;

  vec_t tbl [9];

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc = 0, last_xfer_cyc = 0, xfer_cnt = 0, ovf_cnt = 0;
  int          valid_pct = 0, ready_pct = 0;
  logic [P_W-1:0]   send_q [$];
  logic [ACC_W:0]   exp_q  [$];
  logic [ACC_W:0]   exp_e;
  logic [P_W-1:0]   op_data = 32'h0;
  logic [P_W-1:0]   s1_data;
  logic             s1_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < VEC_LEN; k++) send_q.push_back(v.p[k]);
    exp_q.push_back({v.sat, v.sum});
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    check("drain_within_budget", 64'(n < limit), 64'd1);
    send_q.delete();
    exp_q.delete();
    tick();
    tick();
  endtask

  // Reference saturating accumulate used by the random soak.
  function automatic logic [ACC_W:0] model_add(input logic [ACC_W:0] st, input logic [P_W-1:0] p);
    logic [63:0] s;
    s = 64'(st[ACC_W-1:0]) + 64'(p);
    if (s > 64'(ACC_MAX)) return {1'b1, ACC_MAX};
    else                  return {st[ACC_W], s[ACC_W-1:0]};
  endfunction

  // mult_top stand-in: two registered stages from operand transfer to p_in.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= 32'h0;
      p_in    <= 32'h0;
    end else begin
      s1_v    <= op_valid && op_ready;
      s1_data <= op_data;
      p_in    <= s1_v ? s1_data : 32'hDEAD_BEEF;
      cyc     <= cyc + 1;
      if (op_valid && op_ready) begin
        xfer_cnt      <= xfer_cnt + 1;
        last_xfer_cyc <= cyc + 1;
      end
      if (dut.v2_r && (int'(dut.occ_r) == FIFO_DEPTH) && !clr) ovf_cnt <= ovf_cnt + 1;
    end
  end

  // Operand source and result scoreboard, acting mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      op_valid  = 1'b0;
      acc_ready = 1'b0;
    end else begin
      acc_ready = ($urandom_range(99) < ready_pct);
      if (acc_valid && acc_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(acc_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("acc_out", 64'(acc_out), 64'(exp_e[ACC_W-1:0]));
          check("acc_sat", 64'(acc_sat), 64'(exp_e[ACC_W]));
        end
      end
      op_valid = (send_q.size() > 0) && ($urandom_range(99) < valid_pct);
      op_data  = op_valid ? send_q[0] : 32'h0;
      if (op_valid && op_ready) void'(send_q.pop_front());
    end
  end

  initial begin
    bit   saw;
    int   base;
    logic [ACC_W:0] st;
    vec_t v;

    // Hand-computed dot products.
    for (int k = 0; k < VEC_LEN; k++) begin
      tbl[0].p[k] = 32'(k + 1);
      tbl[1].p[k] = 32'd2;
      tbl[4].p[k] = 32'hFFFF_FFFF;
      tbl[5].p[k] = 32'd1;
      tbl[6].p[k] = (k < 4) ? 32'hFFFF_FFFF : ((k < 7) ? 32'd1 : 32'd0);
      tbl[7].p[k] = (k < 4) ? 32'hFFFF_FFFF : 32'd1;
      tbl[8].p[k] = 32'h1000_0000;
    end
    tbl[0].sum = 34'd36;         tbl[0].sat = 1'b0;
    tbl[1].sum = 34'd16;         tbl[1].sat = 1'b0;
    tbl[4].sum = 34'h3FFFFFFFF;  tbl[4].sat = 1'b1;
    tbl[5].sum = 34'd8;          tbl[5].sat = 1'b0;
    tbl[6].sum = 34'h3FFFFFFFF;  tbl[6].sat = 1'b0;
    tbl[7].sum = 34'h3FFFFFFFF;  tbl[7].sat = 1'b1;
    tbl[8].sum = 34'h080000000;  tbl[8].sat = 1'b0;
    tbl[2] = tbl[1];
    tbl[3] = tbl[1];

    #12;
    check("rst_acc_out",   64'(acc_out),   64'd0);
    check("rst_acc_sat",   64'(acc_sat),   64'd0);
    check("rst_acc_valid", 64'(acc_valid), 64'd0);
    check("rst_op_ready",  64'(op_ready),  64'd1);
    #11 rst = 1'b0;
    tick();

    // Back-to-back vector 1..8: latency and single-cycle valid.
    valid_pct = 100; ready_pct = 100;
    load_vec(tbl[0]);
    saw = 1'b0;
    for (int i = 0; i < 40 && !saw; i++) begin
      tick();
      saw = acc_valid;
    end
    check("t1_valid_seen", 64'(saw), 64'd1);
    check("t1_latency", 64'(cyc - last_xfer_cyc), 64'd3);
    tick();
    check("t1_valid_one_cycle", 64'(acc_valid), 64'd0);
    drain(200);

    // Three vectors under held acc_ready=0.
    ready_pct = 0;
    for (int i = 1; i <= 3; i++) load_vec(tbl[i]);
    saw = 1'b0;
    for (int i = 0; i < 60 && !saw; i++) begin
      tick();
      saw = !op_ready;
    end
    check("t2_op_ready_drops", 64'(saw), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 64'(acc_valid), 64'd1);
      check("t2_hold_value", 64'(acc_out), 64'd16);
      tick();
    end
    check("t2_products_waiting", 64'(send_q.size() > 0), 64'd1);
    ready_pct = 100;
    drain(300);

    // Saturation and boundary vectors.
    for (int i = 4; i <= 8; i++) load_vec(tbl[i]);
    drain(400);

    // clr after 5 products accumulated and 2 in flight.
    base = int'(xfer_cnt);
    for (int k = 0; k < 7; k++) send_q.push_back(32'd5);
    for (int i = 0; i < 40 && int'(xfer_cnt) != base + 7; i++) tick();
    check("t4_seven_sent", 64'(xfer_cnt), 64'(base + 7));
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_no_valid_after_clr", 64'(acc_valid), 64'd0);
    load_vec(tbl[5]);
    drain(200);

    // Async reset while a result is held and more products are in flight.
    ready_pct = 0;
    load_vec(tbl[0]);
    for (int k = 0; k < 4; k++) send_q.push_back(32'd7);
    saw = 1'b0;
    for (int i = 0; i < 40 && !saw; i++) begin
      tick();
      saw = acc_valid;
    end
    tick();
    tick();
    check("t5_held_before_rst", 64'(acc_out), 64'd36);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_acc_valid", 64'(acc_valid), 64'd0);
    check("t5_rst_acc_out",   64'(acc_out),   64'd0);
    check("t5_rst_acc_sat",   64'(acc_sat),   64'd0);
    check("t5_rst_op_ready",  64'(op_ready),  64'd1);
    send_q.delete();
    exp_q.delete();
    #2 rst = 1'b0;
    tick();
    ready_pct = 100;
    load_vec(tbl[8]);
    drain(200);

    // Random soak against the saturating reference model.
    valid_pct = 70; ready_pct = 60;
    for (int n = 0; n < 1000; n++) begin
      st = {1'b0, {ACC_W{1'b0}}};
      for (int k = 0; k < VEC_LEN; k++) begin
        case ($urandom_range(9))
          0:       v.p[k] = 32'hFFFF_FFFF;
          1, 2, 3: v.p[k] = $urandom;
          default: v.p[k] = 32'($urandom_range(65535)) * 32'($urandom_range(65535));
        endcase
        st = model_add(st, v.p[k]);
      end
      v.sum = st[ACC_W-1:0];
      v.sat = st[ACC_W];
      load_vec(v);
    end
    drain(60000);

    check("fifo_overflow_events", 64'(ovf_cnt), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
